// File: rtl/seq_detector_prog_if.sv
// Bus bundle for seq_detector_prog.
// The master side drives the serial bit, its qualifier, the mode control and
// the pattern-load port. The slave side (the detector) returns the match flag
// and the current matched prefix length.
// Optional macro SEQ_DET_CNT_EN adds the det_count return signal.
interface seq_detector_prog_if #(
    parameter int PAT_LEN = 6,
    parameter int ML_W    = $clog2(PAT_LEN)
);
    logic               in;
    logic               in_valid;
    logic               ovl_mode;
    logic               pat_load;
    logic [PAT_LEN-1:0] pat_in;
    logic               detect;
    logic [ML_W-1:0]    match_len;
`ifdef SEQ_DET_CNT_EN
    logic [15:0]        det_count;

    modport master (
        output in, in_valid, ovl_mode, pat_load, pat_in,
        input  detect, match_len, det_count
    );

    modport slave (
        input  in, in_valid, ovl_mode, pat_load, pat_in,
        output detect, match_len, det_count
    );
`else
    modport master (
        output in, in_valid, ovl_mode, pat_load, pat_in,
        input  detect, match_len
    );

    modport slave (
        input  in, in_valid, ovl_mode, pat_load, pat_in,
        output detect, match_len
    );
`endif
endinterface

// File: rtl/seq_detector_prog.sv
// Programmable Mealy serial-pattern detector.
// Tracks the length of the longest pattern prefix that ends the qualified bit
// stream and raises detect combinationally in the cycle the last pattern bit
// arrives. The fallback length after a mismatch (or after a full match in
// overlapping mode) is derived from the live pattern register, so a pattern
// loaded at runtime is handled exactly like the reset pattern.
// Optional macro SEQ_DET_CNT_EN adds a saturating 16-bit detect counter.
module seq_detector_prog #(
    parameter int                 PAT_LEN = 6,
    parameter logic [PAT_LEN-1:0] PAT_RST = 6'b110110,
    parameter int                 ML_W    = $clog2(PAT_LEN)
) (
    input logic               clk,
    input logic               rst,
    seq_detector_prog_if.slave bus
);

    localparam logic [ML_W-1:0] ST_LAST = ML_W'(PAT_LEN - 1);

    logic [PAT_LEN-1:0] pat_q;
    logic [ML_W-1:0]    st;
    logic [ML_W-1:0]    st_nxt;
    logic               step;
    logic               full_match;

    // Last st+1 bits of the candidate (matched prefix followed by the new
    // bit), right-aligned so that bit 0 is the bit arriving this cycle.
    logic [PAT_LEN:0]   cand_tail;
    logic [PAT_LEN:0]   pfx;
    logic [PAT_LEN:0]   mask;
    logic [ML_W-1:0]    fall_len;

    // A bit is consumed only when qualified and no load is in progress.
    assign step       = bus.in_valid & ~bus.pat_load;
    assign full_match = step && (st == ST_LAST) && (bus.in == pat_q[0]);

    assign bus.detect    = full_match;
    assign bus.match_len = st;

    // Longest pattern prefix (shorter than the full pattern) that is a
    // suffix of the candidate; on a full match this is the longest border.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned (which would infer a latch).
        cand_tail    = ({1'b0, pat_q} >> (PAT_LEN - int'(st))) << 1;
        cand_tail[0] = bus.in;
        pfx          = '0;
        mask         = '0;
        fall_len     = '0;
        for (int j = 1; j < PAT_LEN; j++) begin
            mask = {(PAT_LEN + 1){1'b1}} >> (PAT_LEN + 1 - j);
            pfx  = {1'b0, pat_q} >> (PAT_LEN - j);
            if ((j <= int'(st) + 1) && ((cand_tail & mask) == pfx)) begin
                fall_len = ML_W'(j);
            end
        end
    end

    // Next matched-prefix length: load restarts, gaps hold, and a full
    // match in non-overlapping mode restarts from an empty prefix.
    always_comb begin
        st_nxt = st;
        if (bus.pat_load) begin
            st_nxt = '0;
        end else if (bus.in_valid) begin
            if (full_match && !bus.ovl_mode) begin
                st_nxt = '0;
            end else begin
                st_nxt = fall_len;
            end
        end
    end

    // Matched-prefix state register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst) begin
            st <= '0;
        end else begin
            st <= st_nxt;
        end
    end

    // Pattern register, reloaded from pat_in on request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q <= PAT_RST;
        end else if (bus.pat_load) begin
            pat_q <= bus.pat_in;
        end
    end

`ifdef SEQ_DET_CNT_EN
    logic [15:0] det_count_q;

    assign bus.det_count = det_count_q;

    // Saturating count of detect pulses, cleared whenever a pattern loads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            det_count_q <= '0;
        end else if (bus.pat_load) begin
            det_count_q <= '0;
        end else if (full_match && (det_count_q != 16'hFFFF)) begin
            det_count_q <= det_count_q + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_seq_detector_prog.sv
// Scoreboard bench for seq_detector_prog.
// The driver applies one input vector per cycle, asks a string-matching
// reference model (history of accepted bits searched for the pattern) what
// the DUT must show during that cycle, and queues the answer. A monitor on
// the falling edge pops each entry and compares it with the DUT outputs.
// Build with SEQ_DET_CNT_EN defined to include the detect-counter checks.
module tb_seq_detector_prog;

    localparam int                 PAT_LEN = 6;
    localparam int                 ML_W    = $clog2(PAT_LEN);
    localparam logic [PAT_LEN-1:0] PAT_RST = 6'b110110;

    typedef struct {
        logic            det;
        logic [ML_W-1:0] ml;
        logic [15:0]     cnt;
    } exp_t;

    logic clk;
    logic rst;

    seq_detector_prog_if #(.PAT_LEN(PAT_LEN), .ML_W(ML_W)) bus ();

    seq_detector_prog #(
        .PAT_LEN(PAT_LEN),
        .PAT_RST(PAT_RST),
        .ML_W   (ML_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    exp_t sb_q[$];

    // Reference model state: accepted bits since the last restart, the
    // pattern in force and the detect count.
    bit                 hist[$];
    logic [PAT_LEN-1:0] m_pat = PAT_RST;
    int                 m_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Longest k (1..max_k) such that the last k history bits equal the first
    // k pattern bits; 0 when there is none.
    function automatic int longest(input int max_k);
        for (int k = max_k; k >= 1; k--) begin
            if (k <= hist.size()) begin
                bit ok;
                ok = 1'b1;
                for (int i = 0; i < k; i++) begin
                    if (hist[hist.size() - k + i] != m_pat[PAT_LEN-1-i]) ok = 1'b0;
                end
                if (ok) return k;
            end
        end
        return 0;
    endfunction

    // Apply one cycle of stimulus and queue the expected response.
    task automatic step(input bit v, input bit b, input bit ovl, input bit ld,
                        input logic [PAT_LEN-1:0] pin);
        exp_t e;
        bus.in_valid = v;
        bus.in       = b;
        bus.ovl_mode = ovl;
        bus.pat_load = ld;
        bus.pat_in   = pin;
        e.ml  = ML_W'(longest(PAT_LEN - 1));
        e.det = 1'b0;
        e.cnt = 16'(m_cnt);
        if (ld) begin
            m_pat = pin;
            hist.delete();
            m_cnt = 0;
        end else if (v) begin
            hist.push_back(b);
            if (hist.size() > PAT_LEN) hist.delete(0);
            if (longest(PAT_LEN) == PAT_LEN) begin
                e.det = 1'b1;
                if (m_cnt < 65535) m_cnt++;
                if (!ovl) hist.delete();
            end
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Send n bits MSB-first, all valid.
    task automatic send_bits(input logic [31:0] bits, input int n, input bit ovl);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b1, bits[i], ovl, 1'b0, '0);
        end
    endtask

    // Hold reset low for the given number of cycles with a valid bit driven;
    // the detector must show idle outputs throughout.
    task automatic do_reset(input int cycles);
        exp_t e;
        #1;
        rst          = 1'b0;
        bus.in_valid = 1'b1;
        bus.in       = 1'b1;
        bus.pat_load = 1'b0;
        hist.delete();
        m_pat = PAT_RST;
        m_cnt = 0;
        e.det = 1'b0;
        e.ml  = '0;
        e.cnt = '0;
        for (int i = 0; i < cycles; i++) begin
            sb_q.push_back(e);
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
    endtask

    // Monitor: compare each queued expectation mid-cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("detect", 32'(bus.detect), 32'(e.det));
            check("match_len", 32'(bus.match_len), 32'(e.ml));
`ifdef SEQ_DET_CNT_EN
            check("det_count", 32'(bus.det_count), 32'(e.cnt));
`endif
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b0;
        bus.in       = 1'b0;
        bus.in_valid = 1'b0;
        bus.ovl_mode = 1'b1;
        bus.pat_load = 1'b0;
        bus.pat_in   = '0;
        @(posedge clk);
        #1;
        do_reset(2);

        // Default pattern, overlapping then non-overlapping.
        send_bits(32'b110110110, 9, 1'b1);
        do_reset(1);
        send_bits(32'b110110110, 9, 1'b0);

        // Longer prefix collapse, without and with an idle gap.
        do_reset(1);
        send_bits(32'b1110110, 7, 1'b1);
        do_reset(1);
        send_bits(32'b1110, 4, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0, '0);
        send_bits(32'b110, 3, 1'b1);

        // Runtime load beats a simultaneous valid bit.
        step(1'b1, 1'b1, 1'b1, 1'b1, 6'b101010);
        send_bits(32'b1010101010, 10, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 6'b101010);
        send_bits(32'b1010101010, 10, 1'b0);

        // Reset mid-stream discards the partial match.
        do_reset(1);
        send_bits(32'b11011, 5, 1'b1);
        do_reset(2);
        send_bits(32'b0, 1, 1'b1);
        send_bits(32'b110110, 6, 1'b1);

        // Randomized traffic, biased toward the expected next bit.
        for (int n = 0; n < 3000; n++) begin
            int r;
            bit b;
            r = int'($urandom_range(0, 999));
            if (r < 4) begin
                do_reset(2);
            end else begin
                if ($urandom_range(0, 1) == 0) b = m_pat[PAT_LEN-1-longest(PAT_LEN-1)];
                else                           b = 1'($urandom_range(0, 1));
                step($urandom_range(0, 9) < 8, b, $urandom_range(0, 3) != 0,
                     r < 15, PAT_LEN'($urandom));
            end
        end

        // Degenerate patterns: runs of identical bits detect every cycle.
        step(1'b0, 1'b0, 1'b1, 1'b1, '1);
        send_bits(32'hFFFF, 12, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, '0);
        send_bits(32'h0, 12, 1'b1);

`ifdef SEQ_DET_CNT_EN
        // Drive the detect counter into saturation, then clear it by load.
        step(1'b0, 1'b0, 1'b1, 1'b1, '1);
        for (int i = 0; i < 65545; i++) step(1'b1, 1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 1'b1, '1);
        step(1'b0, 1'b0, 1'b1, 1'b0, '0);
`endif

        step(1'b0, 1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        check("scoreboard_drain", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
